// File: rtl/apb_m.sv
// APB requester: accepts one local command at a time, runs SETUP/ACCESS on the
// APB bus, then holds the read data and error status on a valid/ready response port.
module apb_m #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk_i,
  input  logic              preset_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic              cmd_write_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              rsp_timeout_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i,
  input  logic              pslverr_i
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // A zero TIMEOUT still needs a legal one-bit counter even though it is unused.
  localparam int             CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);
  localparam bit             TO_EN = (TIMEOUT != 0);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  assign cmd_ready_o = (state_q == ST_IDLE) && !preset_i;
  assign cnt_inc     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : (cnt_q + CNT_W'(1));

  // Next-state and datapath decode for the transfer sequencer.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pwrite_d      = pwrite_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          paddr_d       = cmd_addr_i;
          pwrite_d      = cmd_write_i;
          pwdata_d      = cmd_wdata_i;
          psel_d        = 1'b1;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b0;
          rsp_rdata_d   = {DATA_W{1'b0}};
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b0;
          state_d       = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = {CNT_W{1'b0}};
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready_i) begin
          rsp_rdata_d   = pwrite_q ? {DATA_W{1'b0}} : prdata_i;
          rsp_err_d     = pslverr_i;
          rsp_timeout_d = 1'b0;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = ST_RESP;
        end else begin
          cnt_d = cnt_inc;
          // cnt_inc counts this wait cycle, so the abort lands on the TIMEOUT-th one.
          if (TO_EN && (cnt_inc == TO_LIMIT)) begin
            psel_d        = 1'b0;
            penable_d     = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_rdata_d   = {DATA_W{1'b0}};
            state_d       = ST_RESP;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_RESP: begin
        if (rsp_valid_q && rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= {CNT_W{1'b0}};
      paddr_q       <= {ADDR_W{1'b0}};
      pwdata_q      <= {DATA_W{1'b0}};
      pwrite_q      <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= {DATA_W{1'b0}};
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pwrite_q      <= pwrite_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign paddr_o       = paddr_q;
  assign pwdata_o      = pwdata_q;
  assign pwrite_o      = pwrite_q;
  assign psel_o        = psel_q;
  assign penable_o     = penable_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_apb_m.sv
// Directed self-checking bench for apb_m: the APB slave side is driven by hand
// step by step and every expected value is written out explicitly.
module tb_apb_m;

  logic        pclk = 1'b0;
  logic        preset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  pwdata;
  logic [7:0]  prdata;
  logic        pready;
  logic        pslverr;

  int n_cmp = 0;
  int n_err = 0;

  apb_m #(.ADDR_W(32), .DATA_W(8), .TIMEOUT(16)) dut (
    .pclk_i(pclk), .preset_i(preset),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_addr_i(cmd_addr), .cmd_write_i(cmd_write), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
    .paddr_o(paddr), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .pwdata_o(pwdata), .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus(input string tag, input logic s, input logic e, input logic v);
    chk({tag, "_psel"}, {31'd0, psel}, {31'd0, s});
    chk({tag, "_penable"}, {31'd0, penable}, {31'd0, e});
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, {31'd0, v});
  endtask

  task automatic rsp(input string tag, input logic [7:0] d, input logic er, input logic to);
    chk({tag, "_rdata"}, {24'd0, rsp_rdata}, {24'd0, d});
    chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, er});
    chk({tag, "_timeout"}, {31'd0, rsp_timeout}, {31'd0, to});
  endtask

  task automatic issue(input logic [31:0] a, input logic w, input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_write = w;
    cmd_wdata = d;
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_hs_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_hs_ready"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    preset = 1'b1; cmd_valid = 1'b0; cmd_addr = 32'd0; cmd_write = 1'b0;
    cmd_wdata = 8'd0; rsp_ready = 1'b0; prdata = 8'd0; pready = 1'b0; pslverr = 1'b0;
    tick();
    tick();
    bus("rst", 1'b0, 1'b0, 1'b0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    rsp("rst", 8'h00, 1'b0, 1'b0);
    preset = 1'b0;
    #1;
    chk("rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // 1: zero-wait write; pready already high during SETUP must be ignored
    issue(32'h5, 1'b1, 8'hA5);
    tick();
    cmd_valid = 1'b0;
    pready = 1'b1;
    bus("t1_setup", 1'b1, 1'b0, 1'b0);
    chk("t1_paddr", paddr, 32'h5);
    chk("t1_pwdata", {24'd0, pwdata}, 32'hA5);
    chk("t1_pwrite", {31'd0, pwrite}, 32'd1);
    chk("t1_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    tick();
    bus("t1_access", 1'b1, 1'b1, 1'b0);
    tick();
    bus("t1_resp", 1'b0, 1'b0, 1'b1);
    rsp("t1", 8'h00, 1'b0, 1'b0);
    pready = 1'b0;
    handshake("t1");
    chk("t1_paddr_hold", paddr, 32'h5);

    // 2: read with two wait states
    issue(32'h5, 1'b0, 8'h00);
    tick();
    cmd_valid = 1'b0;
    bus("t2_setup", 1'b1, 1'b0, 1'b0);
    tick();
    bus("t2_acc0", 1'b1, 1'b1, 1'b0);
    tick();
    bus("t2_wait1", 1'b1, 1'b1, 1'b0);
    tick();
    bus("t2_wait2", 1'b1, 1'b1, 1'b0);
    chk("t2_paddr", paddr, 32'h5);
    chk("t2_pwrite", {31'd0, pwrite}, 32'd0);
    pready = 1'b1;
    prdata = 8'hA5;
    tick();
    bus("t2_resp", 1'b0, 1'b0, 1'b1);
    rsp("t2", 8'hA5, 1'b0, 1'b0);
    pready = 1'b0;
    prdata = 8'h00;
    handshake("t2");

    // 3: write answered with pslverr; read data on the bus must not leak
    issue(32'h14, 1'b1, 8'h3C);
    tick();
    cmd_valid = 1'b0;
    tick();
    pready = 1'b1; pslverr = 1'b1; prdata = 8'h77;
    tick();
    bus("t3_resp", 1'b0, 1'b0, 1'b1);
    rsp("t3", 8'h00, 1'b1, 1'b0);
    pready = 1'b0; pslverr = 1'b0; prdata = 8'h00;
    handshake("t3");

    // 4: slave never ready -> abort on the 16th ACCESS cycle
    issue(32'h9, 1'b0, 8'h00);
    tick();
    cmd_valid = 1'b0;
    prdata = 8'hFF;
    tick();
    for (int i = 0; i < 15; i++) tick();
    bus("t4_last_wait", 1'b1, 1'b1, 1'b0);
    tick();
    bus("t4_abort", 1'b0, 1'b0, 1'b1);
    rsp("t4", 8'h00, 1'b1, 1'b1);
    prdata = 8'h00;
    handshake("t4");

    // 5: response back-pressure with a new command waiting
    issue(32'h3, 1'b0, 8'h00);
    pready = 1'b1;
    prdata = 8'h5A;
    tick();
    tick();
    tick();
    bus("t5_resp", 1'b0, 1'b0, 1'b1);
    issue(32'h7, 1'b1, 8'h11);
    prdata = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tick();
      bus("t5_hold", 1'b0, 1'b0, 1'b1);
      rsp("t5_hold", 8'h5A, 1'b0, 1'b0);
      chk("t5_hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    bus("t5_hs", 1'b0, 1'b0, 1'b0);
    chk("t5_hs_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    bus("t5_next_setup", 1'b1, 1'b0, 1'b0);
    chk("t5_next_paddr", paddr, 32'h7);
    chk("t5_next_pwdata", {24'd0, pwdata}, 32'h11);
    tick();
    tick();
    bus("t5_next_resp", 1'b0, 1'b0, 1'b1);
    rsp("t5_next", 8'h00, 1'b0, 1'b0);
    pready = 1'b0;
    handshake("t5");

    // 6: reset during ACCESS of a read, then a normal write
    issue(32'hB, 1'b0, 8'h00);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    bus("t6_acc", 1'b1, 1'b1, 1'b0);
    preset = 1'b1;
    tick();
    bus("t6_rst", 1'b0, 1'b0, 1'b0);
    chk("t6_rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    preset = 1'b0;
    #1;
    chk("t6_rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    issue(32'h2, 1'b1, 8'h42);
    pready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    bus("t6_w_setup", 1'b1, 1'b0, 1'b0);
    chk("t6_w_pwdata", {24'd0, pwdata}, 32'h42);
    tick();
    bus("t6_w_access", 1'b1, 1'b1, 1'b0);
    tick();
    bus("t6_w_resp", 1'b0, 1'b0, 1'b1);
    rsp("t6_w", 8'h00, 1'b0, 1'b0);
    pready = 1'b0;
    handshake("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
